vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing: pixel coordinates, display-enable and H/V sync.
//  Drives DrawX/DrawY/blank into every sprite/ROM pixel pipeline.
//  Pixel pipelines register colour one vga_clk after DrawX/DrawY. hs/vs are
//  therefore delayed by PIPE_DELAY cycles so that sync lines up with colour at the DAC.
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BACK      33   vertical back porch, lines
//  SYNC_POL    0    asserted level of hs/vs (0 = active-low)
//  PIPE_DELAY  1    register stages on hs/vs (0..3)
// PORTS
//  vga_clk      in   1   pixel clock; all logic is on its posedge
//  Reset        in   1   synchronous, active-high
//  DrawX        out  10  current horizontal count hc (0..H_TOTAL-1)
//  DrawY        out  10  current vertical count vc (0..V_TOTAL-1)
//  blank        out  1   1 = visible pixel (hc<H_VISIBLE && vc<V_VISIBLE), 0 = blanking
//  hs           out  1   horizontal sync, delayed PIPE_DELAY cycles
//  vs           out  1   vertical sync, delayed PIPE_DELAY cycles
//  sync         out  1   composite sync, tied 0
//  line_start   out  1   1 while hc==0
//  frame_start  out  1   1 while hc==0 && vc==0
// BEHAVIOUR
//  - H_TOTAL = sum of the four H_* parameters (default 800).
//  - V_TOTAL = sum of the four V_* parameters (default 525).
//  - Both totals must be <= 1024; elaboration error otherwise.
//  - hc increments every cycle. At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
//  - At hc==H_TOTAL-1 && vc==V_TOTAL-1, both counters wrap to 0 on the same edge.
//  - DrawX, DrawY, blank, line_start and frame_start are decoded from the counter
//    registers. They have zero latency relative to hc/vc.
//  - DrawX and DrawY keep counting through blanking. Consumers gate on blank.
//  - Raw sync active: hs_raw while H_VISIBLE+H_FRONT <= hc < that + H_SYNC
//    (656..751); vs_raw while V_VISIBLE+V_FRONT <= vc < that + V_SYNC (490..491).
//  - hs/vs = raw sync passed through a PIPE_DELAY-deep shift register.
//    Asserted level = SYNC_POL. PIPE_DELAY=0 means combinational from the counters.
//  - Reset: hc=0, vc=0 on the next edge. Every sync pipeline stage loads the deasserted
//    level (~SYNC_POL), so hs=vs=1 by default.
//  - Reset outputs: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, sync=0.
//  - Reset mid-frame: takes priority over the count on the same edge. No partial line is finished.
//  - frame_start therefore asserts in the first cycle after Reset deasserts, and
//    again every H_TOTAL*V_TOTAL cycles (420000 by default).
//  - No other state. There is no enable; the raster runs free whenever Reset is low.
// TESTING
//  1 Reset high 3 cycles, then low -> first cycle: DrawX=0, DrawY=0, blank=1,
//    frame_start=1, hs=1, vs=1.
//  2 Run 800 cycles -> DrawX 799->0 while DrawY 0->1; line_start=1 exactly at DrawX=0.
//  3 hs with PIPE_DELAY=1 -> hs=0 for exactly 96 cycles, covering DrawX=657..752;
//    hs=1 at DrawX=656 and 753.
//  4 blank -> 0 for DrawX 640..799 on every line. 0 for all cycles of DrawY 480..524.
//    1 at (639,479).
//  5 Full frame -> vs=0 for 1600 cycles (lines 490..491, shifted by 1 cycle).
//    Next frame_start 420000 cycles after the previous one. DrawY wraps 524->0.
//  6 Reset asserted at DrawX=300, DrawY=200 -> next edge DrawX=0, DrawY=0, hs=vs=1.
//    Counting resumes at DrawX=1 one cycle after Reset drops.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with decoded coordinates,
// display enable, frame/line markers and H/V sync delayed to line up with registered pixel colour.
module vga_timing_gen #(
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 3) begin : g_pipe_chk
      $error("vga_timing_gen: PIPE_DELAY must be 0..3");
    end
  endgenerate

  // Boundaries are 11 bits wide so a 1024-count raster does not alias to zero.
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [10:0] hc_ext, vc_ext;
  logic        hs_raw, vs_raw;
  logic        hs_lvl, vs_lvl;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
  end

  // Reset wins over the count: a partially drawn line is abandoned.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_ext = {1'b0, hc_q};
  assign vc_ext = {1'b0, vc_q};

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = (hc_ext < H_VIS_END) && (vc_ext < V_VIS_END);
  assign line_start  = (hc_q == 10'd0);
  assign frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
  assign sync        = 1'b0;

  assign hs_raw = (hc_ext >= H_SYNC_START) && (hc_ext < H_SYNC_END);
  assign vs_raw = (vc_ext >= V_SYNC_START) && (vc_ext < V_SYNC_END);
  assign hs_lvl = hs_raw ? SYNC_POL : ~SYNC_POL;
  assign vs_lvl = vs_raw ? SYNC_POL : ~SYNC_POL;

  // Sync is delayed to match the pixel pipeline's registered colour.
  generate
    if (PIPE_DELAY == 0) begin : g_sync_comb
      assign hs = hs_lvl;
      assign vs = vs_lvl;
    end else begin : g_sync_pipe
      logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
      logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;

      always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        hs_pipe_d[0] = hs_lvl;
        vs_pipe_d[0] = vs_lvl;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_pipe_d[i] = hs_pipe_q[i-1];
          vs_pipe_d[i] = vs_pipe_q[i-1];
        end
      end

      always_ff @(posedge vga_clk) begin
        if (Reset) begin
          hs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
          vs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
        end else begin
          hs_pipe_q <= hs_pipe_d;
          vs_pipe_q <= vs_pipe_d;
        end
      end

      assign hs = hs_pipe_q[PIPE_DELAY-1];
      assign vs = vs_pipe_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 raster for line/hsync timing, plus short-frame
// variants (8 lines) for vsync, frame wrap and a combinational active-high sync build.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic Reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 vga_clk = ~vga_clk;

  logic [9:0] x0, y0, xs, ys, xp, yp;
  logic b0, hs0, vs0, sy0, ls0, fs0;
  logic bs, hss, vss, sys, lss, fss;
  logic bp, hsp, vsp, syp, lsp, fsp;

  vga_timing_gen dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(x0), .DrawY(y0), .blank(b0),
    .hs(hs0), .vs(vs0), .sync(sy0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_s (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(xs), .DrawY(ys), .blank(bs),
    .hs(hss), .vs(vss), .sync(sys), .line_start(lss), .frame_start(fss)
  );

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .SYNC_POL(1'b1), .PIPE_DELAY(0)) dut_p (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(xp), .DrawY(yp), .blank(bp),
    .hs(hsp), .vs(vsp), .sync(syp), .line_start(lsp), .frame_start(fsp)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    cyc = 0;
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL reset_drawx got %0d exp 0", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL reset_drawy got %0d exp 0", y0); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", b0); end
    checks++; if (fs0 !== 1'b1) begin errors++; $display("FAIL reset_frame_start got %b exp 1", fs0); end
    checks++; if (ls0 !== 1'b1) begin errors++; $display("FAIL reset_line_start got %b exp 1", ls0); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", vs0); end
    checks++; if (sy0 !== 1'b0) begin errors++; $display("FAIL reset_sync got %b exp 0", sy0); end
    checks++; if (hsp !== 1'b0) begin errors++; $display("FAIL reset_hs_pos got %b exp 0", hsp); end
    checks++; if (vsp !== 1'b0) begin errors++; $display("FAIL reset_vs_pos got %b exp 0", vsp); end
  endtask

  task automatic test_line_wrap();
    int ls_cnt = 0;
    for (int i = 0; i < 799; i++) begin
      step();
      if (ls0) ls_cnt++;
    end
    checks++; if (ls_cnt != 0) begin errors++; $display("FAIL line_start_midline got %0d exp 0", ls_cnt); end
    checks++; if (x0 !== 10'd799) begin errors++; $display("FAIL wrap_drawx_end got %0d exp 799", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL wrap_drawy_end got %0d exp 0", y0); end
    step();
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL wrap_drawx got %0d exp 0", x0); end
    checks++; if (y0 !== 10'd1) begin errors++; $display("FAIL wrap_drawy got %0d exp 1", y0); end
    checks++; if (ls0 !== 1'b1) begin errors++; $display("FAIL wrap_line_start got %b exp 1", ls0); end
    checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL wrap_frame_start got %b exp 0", fs0); end
  endtask

  task automatic test_hsync_blank();
    int lo_cnt = 0, lo_first = -1, lo_last = -1;
    int hi_cnt = 0, hi_first = -1, hi_last = -1;
    int bl_cnt = 0, bl_first = -1, vs_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (x0 == 10'd656) begin
        checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL hs_at_656 got %b exp 1", hs0); end
      end
      if (x0 == 10'd753) begin
        checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL hs_at_753 got %b exp 1", hs0); end
      end
      if (hs0 === 1'b0) begin
        lo_cnt++; lo_last = int'(x0);
        if (lo_first < 0) lo_first = int'(x0);
      end
      if (hsp === 1'b1) begin
        hi_cnt++; hi_last = int'(xp);
        if (hi_first < 0) hi_first = int'(xp);
      end
      if (b0 === 1'b0) begin
        bl_cnt++;
        if (bl_first < 0) bl_first = int'(x0);
      end
      if (vs0 !== 1'b1) vs_bad++;
      step();
    end
    checks++; if (lo_cnt != 96) begin errors++; $display("FAIL hs_low_width got %0d exp 96", lo_cnt); end
    checks++; if (lo_first != 657) begin errors++; $display("FAIL hs_low_first got %0d exp 657", lo_first); end
    checks++; if (lo_last != 752) begin errors++; $display("FAIL hs_low_last got %0d exp 752", lo_last); end
    checks++; if (hi_cnt != 96) begin errors++; $display("FAIL hs_pos_width got %0d exp 96", hi_cnt); end
    checks++; if (hi_first != 656) begin errors++; $display("FAIL hs_pos_first got %0d exp 656", hi_first); end
    checks++; if (hi_last != 751) begin errors++; $display("FAIL hs_pos_last got %0d exp 751", hi_last); end
    checks++; if (bl_cnt != 160) begin errors++; $display("FAIL hblank_width got %0d exp 160", bl_cnt); end
    checks++; if (bl_first != 640) begin errors++; $display("FAIL hblank_first got %0d exp 640", bl_first); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL vs_idle_line1 got %0d exp 0", vs_bad); end
  endtask

  task automatic test_frame();
    int vs_lo = 0, vs_hi_p = 0, fs_cnt = 0, fs_at = -1, vis_bad = 0;
    for (int c = 1601; c <= 6400; c++) begin
      step();
      if (vss === 1'b0) vs_lo++;
      if (vsp === 1'b1) vs_hi_p++;
      if (fss === 1'b1) begin fs_cnt++; fs_at = c; end
      if (ys >= 10'd4 && bs !== 1'b0) vis_bad++;
      if (c == 3039) begin
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL blank_corner got %b exp 1", bs); end
        checks++; if (ys !== 10'd3) begin errors++; $display("FAIL corner_drawy got %0d exp 3", ys); end
      end
      if (c == 3040) begin
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL blank_past_corner got %b exp 0", bs); end
      end
      if (c == 6399) begin
        checks++; if (ys !== 10'd7) begin errors++; $display("FAIL vwrap_drawy_last got %0d exp 7", ys); end
        checks++; if (xs !== 10'd799) begin errors++; $display("FAIL vwrap_drawx_last got %0d exp 799", xs); end
      end
    end
    checks++; if (vs_lo != 1600) begin errors++; $display("FAIL vs_low_width got %0d exp 1600", vs_lo); end
    checks++; if (vs_hi_p != 1600) begin errors++; $display("FAIL vs_pos_width got %0d exp 1600", vs_hi_p); end
    checks++; if (vis_bad != 0) begin errors++; $display("FAIL vblank_leak got %0d exp 0", vis_bad); end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d exp 1", fs_cnt); end
    checks++; if (fs_at != 6400) begin errors++; $display("FAIL frame_period got %0d exp 6400", fs_at); end
    checks++; if (ys !== 10'd0) begin errors++; $display("FAIL vwrap_drawy got %0d exp 0", ys); end
    checks++; if (y0 !== 10'd8) begin errors++; $display("FAIL full_drawy_line8 got %0d exp 8", y0); end
    checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL full_no_frame_start got %b exp 0", fs0); end
  endtask

  task automatic test_reset_mid();
    repeat (11100 - 6400) step();
    checks++; if (x0 !== 10'd700) begin errors++; $display("FAIL pre_reset_drawx got %0d exp 700", x0); end
    checks++; if (y0 !== 10'd13) begin errors++; $display("FAIL pre_reset_drawy got %0d exp 13", y0); end
    checks++; if (hs0 !== 1'b0) begin errors++; $display("FAIL pre_reset_hs got %b exp 0", hs0); end
    checks++; if (vss !== 1'b0) begin errors++; $display("FAIL pre_reset_vs got %b exp 0", vss); end
    Reset = 1'b1;
    step();
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL mid_reset_drawx got %0d exp 0", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL mid_reset_drawy got %0d exp 0", y0); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL mid_reset_hs got %b exp 1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL mid_reset_vs got %b exp 1", vs0); end
    checks++; if (vss !== 1'b1) begin errors++; $display("FAIL mid_reset_vs_short got %b exp 1", vss); end
    checks++; if (fs0 !== 1'b1) begin errors++; $display("FAIL mid_reset_frame_start got %b exp 1", fs0); end
    checks++; if (hsp !== 1'b0) begin errors++; $display("FAIL mid_reset_hs_pos got %b exp 0", hsp); end
    step();
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL reset_hold_drawx got %0d exp 0", x0); end
    Reset = 1'b0;
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL release_drawx got %0d exp 0", x0); end
    step();
    checks++; if (x0 !== 10'd1) begin errors++; $display("FAIL resume_drawx got %0d exp 1", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL resume_drawy got %0d exp 0", y0); end
    checks++; if (ls0 !== 1'b0) begin errors++; $display("FAIL resume_line_start got %b exp 0", ls0); end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_hsync_blank();
    test_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
